// File: rtl/snd_pkg.sv
// snd_pkg: constants and helpers shared by the sound-path PDM decoder.
package snd_pkg;

    // Width of decoded PCM samples.
    localparam int PCM_W = 16;

    // Number of integrator and comb stages in the CIC decimator.
    localparam int CIC_ORDER = 3;

    // CIC register width for a decimation ratio of 2^decim_log2.
    // A 1-bit input needs CIC_ORDER*log2(R) bits of growth.
    // One extra bit holds the full-scale value R^3 itself.
    function automatic int cic_width(input int decim_log2);
        return CIC_ORDER * decim_log2 + 1;
    endfunction

    // Map a raw comb result c (0..2^(w-1)) onto 16-bit PCM.
    // The w = 16 case (shift left by one) falls out of the w < 17 branch.
    // Full scale 2^(w-1) lands on 65536 and is clamped to 65535.
    function automatic logic [PCM_W-1:0] pcm_scale(input logic [31:0] c, input int w);
        logic [31:0] v;
        if (w > 17)
            v = c >> (w - 17);
        else
            v = c << (17 - w);
        if (v > 32'd65535)
            return '1;
        return v[PCM_W-1:0];
    endfunction

endpackage

// File: rtl/snd_cic_int.sv
// snd_cic_int: one modular (wrap-around) CIC integrator stage.
// o_next is the value the accumulator takes on this edge.
// Stages chain through o_next so a bit reaches the last stage on the edge
// that samples it.
module snd_cic_int #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_next
);

    logic [W-1:0] r_acc;

    assign o_next = r_acc + i_din;

    // Accumulate the input every enabled edge; overflow wraps by design.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_acc <= '0;
        else if (i_en)
            r_acc <= o_next;
    end

endmodule

// File: rtl/snd_pdm_dec.sv
// snd_pdm_dec: 1-bit PDM stream to unsigned 16-bit PCM.
// Uses a 3rd-order CIC decimator with decimation ratio R = 2^DECIM_LOG2.
// Decoded samples leave on a valid/ready port; a sticky overrun flag marks
// samples that were overwritten before being consumed.
// Optional build macro SND_PDM_DEC_SYNC_EN inserts a 2-flop synchronizer
// on pdm_in, for an asynchronous PDM source. This delays every output by
// 2 edges.
module snd_pdm_dec
    import snd_pkg::*;
#(
    parameter int DECIM_LOG2 = 5
) (
    input  logic             m2,
    input  logic             rst_n,
    input  logic             pdm_in,
    output logic [PCM_W-1:0] pcm_out,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int W = cic_width(DECIM_LOG2);
    localparam logic [DECIM_LOG2-1:0] PH_ONE = 1;
    localparam logic [1:0] WARM_DONE = 2'd2;

    logic                  w_x;
    logic                  w_en;
    logic [W-1:0]          w_x_ext;
    logic [W-1:0]          w_int1;
    logic [W-1:0]          w_int2;
    logic [W-1:0]          w_int3;
    logic [W-1:0]          w_c1;
    logic [W-1:0]          w_c2;
    logic [W-1:0]          w_c3;
    logic [PCM_W-1:0]      w_pcm;
    logic                  w_set_ovr;

    logic [DECIM_LOG2-1:0] r_phase;
    logic                  r_vld_p0;
    logic [W-1:0]          r_cap_p0;
    logic [W-1:0]          r_d1_p1;
    logic [W-1:0]          r_d2_p1;
    logic [W-1:0]          r_d3_p1;
    logic [W-1:0]          r_comb_p1;
    logic                  r_vld_p1;
    logic [1:0]            r_warm;
    logic [PCM_W-1:0]      r_pcm;
    logic                  r_valid;
    logic                  r_ovr;

`ifdef SND_PDM_DEC_SYNC_EN
    logic                  r_sync_a;
    logic                  r_sync_b;
    logic [1:0]            r_run;

    // Two-flop synchronizer. r_run holds off the integrators and the phase
    // counter until the first synchronized bit arrives, so windows stay
    // aligned to the pdm_in sampling edges.
    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_a <= 1'b0;
            r_sync_b <= 1'b0;
            r_run    <= 2'b00;
        end else begin
            r_sync_a <= pdm_in;
            r_sync_b <= r_sync_a;
            r_run    <= {r_run[0], 1'b1};
        end
    end

    assign w_x  = r_sync_b;
    assign w_en = r_run[1];
`else
    assign w_x  = pdm_in;
    assign w_en = 1'b1;
`endif

    assign w_x_ext = {{(W-1){1'b0}}, w_x};

    // ---- integrators: run at the input rate ----
    snd_cic_int #(.W(W)) u_int1 (
        .i_clk   (m2),
        .i_rst_n (rst_n),
        .i_en    (w_en),
        .i_din   (w_x_ext),
        .o_next  (w_int1)
    );

    snd_cic_int #(.W(W)) u_int2 (
        .i_clk   (m2),
        .i_rst_n (rst_n),
        .i_en    (w_en),
        .i_din   (w_int1),
        .o_next  (w_int2)
    );

    snd_cic_int #(.W(W)) u_int3 (
        .i_clk   (m2),
        .i_rst_n (rst_n),
        .i_en    (w_en),
        .i_din   (w_int2),
        .o_next  (w_int3)
    );

    // ---- p0: window phase and capture of the last integrator ----
    // Phase counter wraps at R. Its last phase latches the integrator value
    // that includes the final bit of the window.
    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= '0;
            r_vld_p0 <= 1'b0;
            r_cap_p0 <= '0;
        end else begin
            r_vld_p0 <= 1'b0;
            if (w_en) begin
                r_phase <= r_phase + PH_ONE;
                if (&r_phase) begin
                    r_vld_p0 <= 1'b1;
                    r_cap_p0 <= w_int3;
                end
            end
        end
    end

    // ---- p1: comb section, one update per decimated sample ----
    assign w_c1 = r_cap_p0 - r_d1_p1;
    assign w_c2 = w_c1 - r_d2_p1;
    assign w_c3 = w_c2 - r_d3_p1;

    // Differentiate the decimated stream.
    // The first two results are start-up transients and are never presented.
    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_d1_p1   <= '0;
            r_d2_p1   <= '0;
            r_d3_p1   <= '0;
            r_comb_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_warm    <= 2'd0;
        end else begin
            r_vld_p1 <= r_vld_p0 && (r_warm == WARM_DONE);
            if (r_vld_p0) begin
                r_d1_p1   <= r_cap_p0;
                r_d2_p1   <= w_c1;
                r_d3_p1   <= w_c2;
                r_comb_p1 <= w_c3;
                if (r_warm != WARM_DONE)
                    r_warm <= r_warm + 2'd1;
            end
        end
    end

    // ---- p2: scaling and output handshake register ----
    assign w_pcm     = pcm_scale({{(32-W){1'b0}}, r_comb_p1}, W);
    assign w_set_ovr = r_vld_p1 && r_valid && !pcm_ready;

    // Load new samples.
    // A handshake with nothing new arriving empties the register.
    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            r_pcm   <= '0;
            r_valid <= 1'b0;
        end else if (r_vld_p1) begin
            r_pcm   <= w_pcm;
            r_valid <= 1'b1;
        end else if (r_valid && pcm_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overrun.
    // Setting takes priority over a clear on the same edge.
    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n)
            r_ovr <= 1'b0;
        else if (w_set_ovr)
            r_ovr <= 1'b1;
        else if (clr_ovr)
            r_ovr <= 1'b0;
    end

    assign pcm_out   = r_pcm;
    assign pcm_valid = r_valid;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_snd_pdm_dec.sv
// tb_snd_pdm_dec: self-checking bench for snd_pdm_dec with R = 32.
// The reference keeps plain triple running sums of the bit stream.
// Each decoded sample is the third difference of those sums at R-edge
// spacing, scaled to 16 bits. It is delivered 2 edges after the window ends.
module tb_snd_pdm_dec;

    localparam int L = 5;
    localparam int R = 1 << L;
    localparam int W = 3 * L + 1;
`ifdef SND_PDM_DEC_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int FIRST_VLD = 3 * R + 1 + SYNC;

    logic        m2 = 1'b0;
    logic        rst_n = 1'b0;
    logic        pdm_in = 1'b0;
    logic        pcm_ready = 1'b0;
    logic        clr_ovr = 1'b0;
    logic [15:0] pcm_out;
    logic        pcm_valid;
    logic        overrun;

    snd_pdm_dec #(.DECIM_LOG2(L)) dut (
        .m2        (m2),
        .rst_n     (rst_n),
        .pdm_in    (pdm_in),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr)
    );

    always #5 m2 = ~m2;

    int          n_chk = 0;
    int          n_fail = 0;

    // reference state
    int          e;
    longint      s1, s2, s3;
    longint      hist[$];
    bit          xq[$];
    int          due_q[$];
    logic [15:0] val_q[$];
    bit          m_valid, m_ovr;
    logic [15:0] m_out;
    bit          last_new;
    logic [15:0] last_val;
    int          first_vld_e;

    function automatic logic [15:0] ref_scale(input longint c);
        longint v;
        if (W - 1 == 15)
            v = c * 2;
        else if (W > 17)
            v = c / (longint'(1) << (W - 17));
        else
            v = c * (longint'(1) << (17 - W));
        if (v > 65535)
            v = 65535;
        return v[15:0];
    endfunction

    task automatic model_clear();
        e = -1;
        s1 = 0; s2 = 0; s3 = 0;
        hist.delete(); xq.delete(); due_q.delete(); val_q.delete();
        m_valid = 0; m_ovr = 0; m_out = 16'h0;
        last_new = 0; last_val = 16'h0; first_vld_e = -1;
    endtask

    // One m2 edge: drive a bit, advance the reference, compare outputs.
    task automatic tick(input bit x);
        bit     b;
        int     f;
        int     k;
        longint y;
        bit     set;
        pdm_in = x;
        @(posedge m2);
        e++;
        xq.push_back(x);
        if (e >= SYNC) begin
            b = xq.pop_front();
            f = e - SYNC;
            s1 += longint'(b); s2 += s1; s3 += s2;
            if (f % R == R - 1) begin
                k = f / R;
                hist.push_back(s3);
                if (k >= 2) begin
                    y = hist[k] - 3 * hist[k-1] + 3 * hist[k-2] - ((k >= 3) ? hist[k-3] : 64'sd0);
                    due_q.push_back(e + 2);
                    val_q.push_back(ref_scale(y));
                end
            end
        end
        last_new = (due_q.size() > 0) && (due_q[0] == e);
        set = last_new && m_valid && !pcm_ready;
        if (set) m_ovr = 1;
        else if (clr_ovr) m_ovr = 0;
        if (last_new) begin
            m_out = val_q.pop_front();
            void'(due_q.pop_front());
            m_valid = 1;
            last_val = m_out;
        end else if (m_valid && pcm_ready) begin
            m_valid = 0;
        end
        #1;
        n_chk++;
        if (pcm_valid !== m_valid) begin
            n_fail++;
            $display("FAIL pcm_valid edge %0d: got %b expected %b", e, pcm_valid, m_valid);
        end
        n_chk++;
        if (overrun !== m_ovr) begin
            n_fail++;
            $display("FAIL overrun edge %0d: got %b expected %b", e, overrun, m_ovr);
        end
        n_chk++;
        if (pcm_out !== m_out) begin
            n_fail++;
            $display("FAIL pcm_out edge %0d: got %0d expected %0d", e, pcm_out, m_out);
        end
        if (pcm_valid === 1'b1 && first_vld_e < 0)
            first_vld_e = e;
    endtask

    // Assert reset in the middle of a clock period.
    task automatic rst_assert();
        #3;
        rst_n = 0;
        model_clear();
        #1;
    endtask

    // Release reset away from the active edge; the next posedge is edge 0.
    task automatic rst_release();
        repeat (2) @(posedge m2);
        @(negedge m2);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; pcm_ready = 0; clr_ovr = 0;
        model_clear();
        @(posedge m2);
        #1;
        n_chk++;
        if (pcm_out !== 16'h0 || pcm_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got out=%0h vld=%b ovr=%b expected 0/0/0", pcm_out, pcm_valid, overrun);
        end
        @(negedge m2);
        rst_n = 1;
        pcm_ready = 1;
        repeat (R) tick(1'b1);
        n_chk++;
        if (first_vld_e !== -1) begin
            n_fail++;
            $display("FAIL early_valid: got valid at edge %0d expected none", first_vld_e);
        end
    endtask

    task automatic test_ones();
        int nsamp;
        rst_assert(); rst_release();
        pcm_ready = 1; nsamp = 0;
        repeat (5 * R) begin
            tick(1'b1);
            if (last_new) begin
                nsamp++;
                n_chk++;
                if (pcm_out !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL ones_value: got %0h expected ffff", pcm_out);
                end
            end
        end
        n_chk++;
        if (first_vld_e !== FIRST_VLD) begin
            n_fail++;
            $display("FAIL first_valid_edge: got %0d expected %0d", first_vld_e, FIRST_VLD);
        end
        n_chk++;
        if (overrun !== 1'b0 || nsamp < 2) begin
            n_fail++;
            $display("FAIL ones_flow: got ovr=%b samples=%0d expected ovr=0 samples>=2", overrun, nsamp);
        end
    endtask

    task automatic test_zeros();
        int nsamp;
        rst_assert(); rst_release();
        pcm_ready = 1; nsamp = 0;
        repeat (6 * R + 4) begin
            tick(1'b0);
            if (last_new) begin
                nsamp++;
                n_chk++;
                if (pcm_out !== 16'h0) begin
                    n_fail++;
                    $display("FAIL zeros_value: got %0h expected 0", pcm_out);
                end
            end
        end
        n_chk++;
        if (nsamp !== 4) begin
            n_fail++;
            $display("FAIL zeros_count: got %0d expected 4", nsamp);
        end
    endtask

    task automatic test_alternating();
        bit x;
        rst_assert(); rst_release();
        pcm_ready = 1; x = 1;
        repeat (7 * R) begin
            tick(x);
            x = ~x;
            if (last_new) begin
                n_chk++;
                if (pcm_out !== 16'h8000) begin
                    n_fail++;
                    $display("FAIL alt_value: got %0h expected 8000", pcm_out);
                end
            end
        end
    endtask

    // First-order PDM modulator of a constant PCM value, as the DAC would emit.
    task automatic test_loopback();
        int acc;
        int d;
        rst_assert(); rst_release();
        pcm_ready = 1; acc = 0; d = 16'h4000;
        repeat (7 * R) begin
            acc += d;
            tick(acc >= 65536);
            acc &= 65535;
            if (last_new) begin
                n_chk++;
                if (pcm_out < 16'h3FC0 || pcm_out > 16'h4040) begin
                    n_fail++;
                    $display("FAIL loopback_value: got %0h expected 3fc0..4040", pcm_out);
                end
            end
        end
        d = $urandom_range(2000, 63000);
        repeat (8 * R) begin
            acc += d;
            tick(acc >= 65536);
            acc &= 65535;
        end
    endtask

    task automatic test_overrun();
        bit hit;
        rst_assert(); rst_release();
        pcm_ready = 1;
        for (int i = 0; i < 4 * R && first_vld_e < 0; i++)
            tick(bit'($urandom_range(0, 1)));
        n_chk++;
        if (first_vld_e < 0) begin
            n_fail++;
            $display("FAIL ovr_first_valid: got none expected edge %0d", FIRST_VLD);
        end
        pcm_ready = 0;
        repeat (3 * R) tick(bit'($urandom_range(0, 1)));
        n_chk++;
        if (overrun !== 1'b1 || pcm_valid !== 1'b1 || pcm_out !== last_val) begin
            n_fail++;
            $display("FAIL ovr_set: got ovr=%b vld=%b out=%0h expected 1/1/%0h", overrun, pcm_valid, pcm_out, last_val);
        end
        if (due_q.size() > 0 && due_q[0] == e + 1)
            tick(1'b0);
        clr_ovr = 1;
        tick(1'b1);
        clr_ovr = 0;
        n_chk++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: got %b expected 0", overrun);
        end
        hit = 0;
        for (int i = 0; i < 2 * R && !hit; i++) begin
            if (due_q.size() > 0 && due_q[0] == e + 1) begin
                pcm_ready = 1;
                tick(bit'($urandom_range(0, 1)));
                pcm_ready = 0;
                hit = 1;
            end else begin
                tick(bit'($urandom_range(0, 1)));
            end
        end
        n_chk++;
        if (!hit || overrun !== 1'b0 || pcm_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_coincide: got hit=%b ovr=%b vld=%b expected 1/0/1", hit, overrun, pcm_valid);
        end
    endtask

    task automatic test_reset_mid();
        rst_assert(); rst_release();
        pcm_ready = 0;
        repeat (4 * R + R / 2 + 3) tick(bit'($urandom_range(0, 1)));
        n_chk++;
        if (overrun !== 1'b1 || pcm_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_state: got ovr=%b vld=%b expected 1/1", overrun, pcm_valid);
        end
        rst_assert();
        n_chk++;
        if (pcm_out !== 16'h0 || pcm_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got out=%0h vld=%b ovr=%b expected 0/0/0", pcm_out, pcm_valid, overrun);
        end
        rst_release();
        pcm_ready = 1;
        repeat (4 * R) tick(bit'($urandom_range(0, 1)));
        n_chk++;
        if (first_vld_e !== FIRST_VLD) begin
            n_fail++;
            $display("FAIL restart_valid_edge: got %0d expected %0d", first_vld_e, FIRST_VLD);
        end
    endtask

    task automatic test_back_to_back();
        int dens;
        int nsamp;
        rst_assert(); rst_release();
        nsamp = 0;
        for (int seg = 0; seg < 8; seg++) begin
            dens = $urandom_range(0, 100);
            repeat (3 * R) begin
                pcm_ready = ($urandom_range(0, 3) != 0);
                clr_ovr = ($urandom_range(0, 15) == 0);
                tick($urandom_range(0, 99) < dens);
                if (last_new) nsamp++;
            end
        end
        pcm_ready = 0; clr_ovr = 0;
        n_chk++;
        if (nsamp < 20) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected >= 20", nsamp);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_zeros();
        test_alternating();
        test_loopback();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
